// File: rtl/adc_snapshot_capture.sv
// adc_snapshot_capture
//
// Triggered circular snapshot buffer for one RFDC ADC AXI4-Stream master
// (128-bit beats, 8 signed 12-bit samples per beat, sample 0 oldest, each
// sample in bits [16i+15:16i+4]). Once armed it records every valid beat
// into a circular RAM. It fires on a threshold crossing or a forced trigger,
// records post_len further beats and then freezes for readout.
//
// Ports
//   aclk, reset        clock; synchronous active-high reset
//   s_axis_tdata/tvalid input beats; s_axis_tready is tied high (no backpressure)
//   arm                single-cycle arm request (accepted in IDLE and DONE)
//   force_trig         single-cycle software trigger, held pending until used
//   thresh, thresh_en  signed level threshold and its enable
//   post_len           beats recorded after the trigger beat, sampled at arm
//   cap_state          FSM state: 0=IDLE 1=ARMED 2=POST 3=DONE
//   done               high while in DONE
//   trig_addr          RAM address holding the trigger beat
//   rd_addr, rd_data   random-access read port, 2-cycle latency
//
// Build option
//   ADC_CAPTURE_EDGE_EN  when defined, the threshold hit needs a rising
//                        crossing (sample > thresh and previous sample <= thresh)
//                        instead of a plain level compare.
//
// Handshake: tvalid qualifies a beat on every rising edge; tready is always
// 1, so a beat is taken whenever tvalid is high and nothing is ever dropped.

module adc_snapshot_capture #(
  parameter int DEPTH_LOG2  = 10,
  parameter int PRETRIG_MIN = 256
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic [127:0]          s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  arm,
  input  logic                  force_trig,
  input  logic [11:0]           thresh,
  input  logic                  thresh_en,
  input  logic [DEPTH_LOG2-1:0] post_len,
  output logic [1:0]            cap_state,
  output logic                  done,
  output logic [DEPTH_LOG2-1:0] trig_addr,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [127:0]          rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PRE_W = $clog2(PRETRIG_MIN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_done;
  logic [DEPTH_LOG2-1:0] r_trig_addr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_post_cnt;
  logic [PRE_W-1:0]      r_pre_cnt;
  logic                  r_force_pend;
  logic                  r_s1_valid;
  logic [127:0]          r_s1_data;
  logic [127:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rd_addr;
  logic [127:0]          r_rd_data;

  logic [7:0]            w_gt;
  logic                  w_hit;
  logic                  w_pre_ok;
  logic                  w_trig;
  logic                  w_wr_en;
  logic                  w_arm_ok;

`ifdef ADC_CAPTURE_EDGE_EN
  // Last sample of the previous valid beat, used as predecessor of sample 0.
  logic [11:0]           r_prev_s7;
  logic                  r_prev_valid;
`endif

  assign s_axis_tready = 1'b1;
  assign cap_state     = r_state;
  assign done          = r_done;
  assign trig_addr     = r_trig_addr;
  assign rd_data       = r_rd_data;

  // Per-sample strict signed compare and the trigger hit on stage 1.
  always_comb begin
    w_gt  = '0;
    w_hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_gt[i] = $signed(r_s1_data[16*i+4 +: 12]) > $signed(thresh);
    end
`ifdef ADC_CAPTURE_EDGE_EN
    w_hit = w_gt[0] && r_prev_valid && ($signed(r_prev_s7) <= $signed(thresh));
    for (int i = 1; i < 8; i++) begin
      w_hit = w_hit || (w_gt[i] && !w_gt[i-1]);
    end
`else
    w_hit = |w_gt;
`endif
    w_hit = w_hit && thresh_en;
  end

  assign w_arm_ok = arm && (r_state == S_IDLE || r_state == S_DONE);
  assign w_wr_en  = r_s1_valid && (r_state == S_ARMED || r_state == S_POST);
  assign w_pre_ok = (r_pre_cnt == PRE_W'(PRETRIG_MIN));
  assign w_trig   = (r_state == S_ARMED) && r_s1_valid && w_pre_ok &&
                    (w_hit || r_force_pend);

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_done       <= 1'b0;
      r_trig_addr  <= '0;
      r_wr_ptr     <= '0;
      r_post_cnt   <= '0;
      r_pre_cnt    <= '0;
      r_force_pend <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_data    <= '0;
    end else begin
      r_s1_valid <= s_axis_tvalid;
      r_s1_data  <= s_axis_tdata;

      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      // A pending force survives until a trigger is actually taken.
      if (w_arm_ok || w_trig) begin
        r_force_pend <= 1'b0;
      end else if (force_trig && (r_state == S_ARMED || r_state == S_POST)) begin
        r_force_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          // arm wins over any beat sitting in stage 1; that beat is dropped
          if (arm) begin
            r_state    <= S_ARMED;
            r_done     <= 1'b0;
            r_post_cnt <= post_len;
            r_pre_cnt  <= '0;
          end
        end
        S_ARMED: begin
          if (r_s1_valid) begin
            if (!w_pre_ok) begin
              r_pre_cnt <= r_pre_cnt + 1'b1;
            end
            if (w_trig) begin
              r_trig_addr <= r_wr_ptr;
              if (r_post_cnt == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (r_s1_valid) begin
            r_post_cnt <= r_post_cnt - 1'b1;
            if (r_post_cnt == DEPTH_LOG2'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ADC_CAPTURE_EDGE_EN
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_prev_s7    <= '0;
      r_prev_valid <= 1'b0;
    end else if (w_arm_ok) begin
      r_prev_valid <= 1'b0;
    end else if (r_s1_valid) begin
      r_prev_s7    <= r_s1_data[127:116];
      r_prev_valid <= 1'b1;
    end
  end
`endif

  // Capture RAM: no reset so it maps onto block RAM; contents survive reset.
  always_ff @(posedge aclk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= r_s1_data;
    end
  end

  // Registered address and registered output: 2-cycle read latency.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else begin
      r_rd_addr <= rd_addr;
      r_rd_data <= r_mem[r_rd_addr];
    end
  end

endmodule

// File: tb/tb_adc_snapshot_capture.sv
// Directed testbench for adc_snapshot_capture. Inputs change on the falling
// edge and outputs are sampled on the falling edge. After drive(n) returns,
// beat n sits in stage 1 and beats up to n-1 have been evaluated/written.

module tb_adc_snapshot_capture;

  logic         aclk;
  logic         reset;
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         arm;
  logic         force_trig;
  logic [11:0]  thresh;
  logic         thresh_en;
  logic [9:0]   post_len;
  logic [1:0]   cap_state;
  logic         done;
  logic [9:0]   trig_addr;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_q[$];

  adc_snapshot_capture #(.DEPTH_LOG2(10), .PRETRIG_MIN(256)) dut (
    .aclk          (aclk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .arm           (arm),
    .force_trig    (force_trig),
    .thresh        (thresh),
    .thresh_en     (thresh_en),
    .post_len      (post_len),
    .cap_state     (cap_state),
    .done          (done),
    .trig_addr     (trig_addr),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  // clock / watchdog
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Beat n: every sample = base except sample sidx = sval; the ignored low
  // nibbles carry n so each beat is unique in RAM.
  function automatic logic [127:0] mk_beat(input int n, input logic signed [11:0] base,
                                           input int sidx, input logic signed [11:0] sval);
    logic [127:0] b;
    logic [15:0]  nn;
    nn = n[15:0];
    b  = '0;
    for (int i = 0; i < 8; i++) begin
      b[16*i+4 +: 12] = (i == sidx) ? sval : base;
      b[16*i +: 4]    = nn[4*(i%4) +: 4];
    end
    return b;
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [127:0] d, input logic f);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    force_trig    = f;
    arm           = 1'b0;
    @(negedge aclk);
  endtask

  task automatic do_arm(input logic [9:0] pl);
    arm           = 1'b1;
    post_len      = pl;
    s_axis_tvalid = 1'b0;
    force_trig    = 1'b0;
    @(negedge aclk);
    arm = 1'b0;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    s_axis_tvalid = 1'b0;
    arm           = 1'b0;
    force_trig    = 1'b0;
    @(negedge aclk);
    reset = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [9:0] a, input logic [127:0] exp);
    exp_q.push_back(exp);
    rd_addr       = a;
    s_axis_tvalid = 1'b0;
    force_trig    = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    check(tag, rd_data, exp_q.pop_front());
  endtask

  initial begin
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    arm           = 1'b0;
    force_trig    = 1'b0;
    thresh        = '0;
    thresh_en     = 1'b0;
    post_len      = '0;
    rd_addr       = '0;
    @(negedge aclk);
    @(negedge aclk);
    reset = 1'b0;

    // reset state
    check("rst_state", cap_state, 2'd0);
    check("rst_done", done, 1'b0);
    check("rst_trig", trig_addr, 10'd0);
    check("rst_rd", rd_data, 128'd0);
    check("tready", s_axis_tready, 1'b1);

    // forced trigger at beat 300, post_len 16, ramp data
    do_arm(10'd16);
    check("t1_armed", cap_state, 2'd1);
    for (int n = 0; n <= 320; n++) begin
      drive(1'b1, mk_beat(n, 12'(n), -1, 12'sd0), n == 300);
      if (n == 316) check("t1_post", cap_state, 2'd2);
      if (n == 317) begin
        check("t1_done_state", cap_state, 2'd3);
        check("t1_done", done, 1'b1);
      end
    end
    check("t1_trig", trig_addr, 10'h12C);
    rd_check("t1_rd_trig", 10'h12C, mk_beat(300, 12'sd300, -1, 12'sd0));
    rd_check("t1_rd_last", 10'd316, mk_beat(316, 12'sd316, -1, 12'sd0));

    // threshold 100: exactly 100 at beat 350 must not fire, 101 at beat 400 fires
    do_reset();
    thresh    = 12'sd100;
    thresh_en = 1'b1;
    do_arm(10'd4);
    for (int n = 0; n <= 405; n++) begin
      if (n == 350)      drive(1'b1, mk_beat(n, -12'sd5, 2, 12'sd100), 1'b0);
      else if (n == 400) drive(1'b1, mk_beat(n, -12'sd5, 5, 12'sd101), 1'b0);
      else               drive(1'b1, mk_beat(n, -12'sd5, -1, 12'sd0), 1'b0);
      if (n == 400) check("t2_no_fire_at_100", cap_state, 2'd1);
      if (n == 405) check("t2_done", cap_state, 2'd3);
    end
    check("t2_trig", trig_addr, 10'd400);
    rd_check("t2_rd_trig", 10'd400, mk_beat(400, -12'sd5, 5, 12'sd101));

    // force at beat 10 held until pretrigger satisfied at beat 256
    do_reset();
    thresh_en = 1'b0;
    do_arm(10'd2);
    for (int n = 0; n <= 259; n++) begin
      drive(1'b1, mk_beat(n, 12'sd7, -1, 12'sd0), n == 10);
      if (n == 256) check("t3_held", cap_state, 2'd1);
      if (n == 259) check("t3_done", cap_state, 2'd3);
    end
    check("t3_trig", trig_addr, 10'd256);

    // post_len 0: DONE right after the trigger beat, only that beat written
    do_reset();
    do_arm(10'd0);
    for (int n = 0; n <= 259; n++) begin
      drive(1'b1, mk_beat(n, 12'sd9, -1, 12'sd0), n == 0);
      if (n == 256) check("t4_armed", cap_state, 2'd1);
      if (n == 257) check("t4_done", cap_state, 2'd3);
    end
    check("t4_trig", trig_addr, 10'd256);
    rd_check("t4_rd_trig", 10'd256, mk_beat(256, 12'sd9, -1, 12'sd0));
    rd_check("t4_rd_stale", 10'd257, mk_beat(257, 12'sd7, -1, 12'sd0));

    // wrap: trigger at 1020 with post_len 8, last beat lands at address 4
    do_reset();
    do_arm(10'd8);
    for (int n = 0; n <= 1029; n++) begin
      drive(1'b1, mk_beat(n, 12'sd3, -1, 12'sd0), n == 1020);
      if (n == 1028) check("t5_post", cap_state, 2'd2);
      if (n == 1029) check("t5_done", cap_state, 2'd3);
    end
    check("t5_trig", trig_addr, 10'd1020);
    rd_check("t5_rd_last", 10'd4, mk_beat(1028, 12'sd3, -1, 12'sd0));
    rd_check("t5_rd_prev", 10'd3, mk_beat(1027, 12'sd3, -1, 12'sd0));
    rd_check("t5_rd_keep", 10'd5, mk_beat(5, 12'sd3, -1, 12'sd0));
    // arm in DONE with a beat in stage 1: arm wins, beat not written
    drive(1'b1, mk_beat(2000, 12'sd33, -1, 12'sd0), 1'b0);
    do_arm(10'd16);
    check("t5_rearm_state", cap_state, 2'd1);
    check("t5_rearm_done", done, 1'b0);
    rd_check("t5_rd_no_write", 10'd5, mk_beat(5, 12'sd3, -1, 12'sd0));

    // reset in POST, then a clean restart
    do_reset();
    rd_addr = 10'd260;
    do_arm(10'd16);
    for (int n = 0; n <= 265; n++) begin
      drive(1'b1, mk_beat(n, 12'sd11, -1, 12'sd0), n == 260);
    end
    check("t6_post", cap_state, 2'd2);
    check("t6_rd_before", rd_data, mk_beat(260, 12'sd11, -1, 12'sd0));
    do_reset();
    check("t6_rst_state", cap_state, 2'd0);
    check("t6_rst_done", done, 1'b0);
    check("t6_rst_trig", trig_addr, 10'd0);
    check("t6_rst_rd", rd_data, 128'd0);
    do_arm(10'd0);
    for (int n = 0; n <= 257; n++) begin
      drive(1'b1, mk_beat(n, 12'sd13, -1, 12'sd0), n == 0);
    end
    check("t6_restart_done", cap_state, 2'd3);
    check("t6_restart_trig", trig_addr, 10'd256);

    // constant 200 over thresh 100: level fires, edge mode never fires
    do_reset();
    thresh    = 12'sd100;
    thresh_en = 1'b1;
    do_arm(10'd0);
    for (int n = 0; n <= 259; n++) begin
      drive(1'b1, mk_beat(n, 12'sd200, -1, 12'sd0), 1'b0);
    end
`ifdef ADC_CAPTURE_EDGE_EN
    check("t7_edge_no_fire", cap_state, 2'd1);
`else
    check("t7_level_fire", cap_state, 2'd3);
    check("t7_level_trig", trig_addr, 10'd256);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_snapshot_capture.md
Name: adc_snapshot_capture

Overview:
- Triggered circular snapshot buffer sitting directly downstream of one RFDC ADC AXI4-Stream master (128-bit, 8 samples/beat) in the aclk domain.
- Continuously records beats once armed, fires on a threshold crossing or a forced trigger, then records a programmable number of post-trigger beats and freezes.
- A simple random-access read port lets the PS-side register bridge or an ILA transfer stage drain the frozen capture.

Parameters:
- DEPTH_LOG2, 10, log2 of buffer depth in 128-bit beats (1024 beats = 8192 samples).
- PRETRIG_MIN, 256, beats that must be written after arm before any trigger is accepted.

Ports:
- aclk  in  1  RFDC AXI4-Stream clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  128  sample i (i=0..7, i=0 oldest) in bits [16i+15:16i+4], signed 12-bit; bits [16i+3:16i] ignored.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  tied to 1; the RFDC cannot be stalled.
- arm  in  1  single-cycle arm request.
- force_trig  in  1  single-cycle software trigger request.
- thresh  in  12  signed threshold, quasi-static.
- thresh_en  in  1  enables the threshold trigger.
- post_len  in  DEPTH_LOG2  beats recorded after the trigger beat; sampled at arm.
- cap_state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.
- done  out  1  high in DONE.
- trig_addr  out  DEPTH_LOG2  buffer address holding the trigger beat.
- rd_addr  in  DEPTH_LOG2  read address.
- rd_data  out  128  buffer word; 2-cycle latency from rd_addr.

Behaviour:
- Reset (sync, active-high, any state):
  - cap_state=IDLE, done=0, trig_addr=0, rd_data=0.
  - Write pointer = 0, pretrigger counter = 0, pending force cleared, stage-1 register invalid.
  - RAM contents are not cleared.
- Pipeline:
  - Input beat is registered into stage 1 (data + valid).
  - Threshold compare and trigger decision are made on stage 1.
  - A stage-1 beat is written to RAM at wr_ptr in the same cycle.
  - Input-to-RAM latency is 1 cycle.
- Writes occur only in ARMED and POST, and only for valid stage-1 beats. wr_ptr increments per write and wraps modulo 2^DEPTH_LOG2.
- Threshold hit: thresh_en=1 and any of the 8 stage-1 samples > thresh (signed compare, strict).
- force_trig sets a pending flag in any state except IDLE/DONE. The flag is consumed by the next qualifying stage-1 beat. An arm clears the flag.
- Pretrigger counter:
  - Counts writes in ARMED.
  - Saturates at PRETRIG_MIN.
  - Triggers are ignored until it reaches PRETRIG_MIN; a pending force is held, not lost.
- FSM:
  - IDLE: arm -> ARMED. Latch post_len into the post counter, zero the pretrigger counter, wr_ptr keeps its value.
  - ARMED: on a valid stage-1 beat with (hit or pending force) and pretrigger satisfied:
    - write the beat and set trig_addr = wr_ptr;
    - if latched post_len == 0 -> DONE, else -> POST.
  - POST: each write decrements the post counter; the write that takes it from 1 to 0 -> DONE (that beat is written). Triggers are ignored.
  - DONE: no writes; done=1. arm -> ARMED as from IDLE and done drops the next cycle.
- arm in ARMED or POST is ignored.
- Simultaneous arm and trigger beat in DONE: arm wins; the beat is neither written nor evaluated.
- Captured window:
  - Beats trig_addr-(2^DEPTH_LOG2-1-post_len) .. trig_addr+post_len, modulo depth.
  - Pre-trigger data older than the beats written since arm is stale.
  - A post_len >= 2^DEPTH_LOG2 is not range-checked; it overwrites the trigger region.
- Read port:
  - Registered address into BRAM, registered output.
  - Reads are legal in any state; contents are undefined outside DONE.
- s_axis_tvalid gaps stall all counters; no beat is dropped while tvalid=1.

Optional Feature:
- ADC_CAPTURE_EDGE_EN defined: threshold hit requires a rising crossing, i.e. sample i > thresh and the preceding sample <= thresh.
  - For i=0 the preceding sample is sample 7 of the previous valid beat, held in a register.
  - That register is invalid after reset or arm, so the first beat after arm cannot edge-fire on sample 0.
- Undefined: level compare as above.

Test Plan:
- Reset, arm, post_len=16, ramp data, force_trig pulse at beat 300 -> trig_addr=300 (0x12C); DONE after 16 more beats; done=1; rd at 0x12C returns the forced beat 2 cycles later.
- thresh=100, thresh_en=1, sample 5 of beat 400 = 101, all others ≤100 -> trigger on beat 400, trig_addr=400; a value of exactly 100 does not fire.
- force_trig at beat 10 (before PRETRIG_MIN=256) -> held pending, fires on beat 256 (trig_addr=256).
- post_len=0 -> DONE the cycle after the trigger beat is written; exactly one beat is written after arm+256 pretrigger beats.
- Trigger with wr_ptr=1020, post_len=8 -> writes wrap; last beat at address 4; trig_addr=1020.
- Reset asserted in POST -> next cycle cap_state=0, done=0, trig_addr=0, rd_data=0; a subsequent arm restarts cleanly. With ADC_CAPTURE_EDGE_EN, a constant 200 with thresh=100 never fires.
